// File: rtl/windowed_register_file_spill_pkg.sv
// Shared definitions for the windowed register file with spill/fill engine.
package windowed_register_file_spill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SPILL  = 2'd1,
        ST_FILL   = 2'd2,
        ST_COMMIT = 2'd3
    } wf_state_e;

    // Bit positions inside win_err
    localparam int ERR_UNDERFLOW  = 0;
    localparam int ERR_STACK_FULL = 1;

    // Visible register r of window w maps onto the physical ring of nphys registers.
    function automatic int unsigned phys_idx(input int unsigned w, input int unsigned r,
                                             input int unsigned stride, input int unsigned nphys);
        return (w * stride + r) % nphys;
    endfunction

endpackage

// File: rtl/windowed_register_file_spill_win_reg_array.sv
// Physical register ring: datapath write port, fill write port and three combinational
// read ports (two for the datapath, one feeding spill data to memory).
module win_reg_array #(
    parameter  int DATA_W = 16,
    parameter  int NPHYS  = 8,
    localparam int IDX_W  = $clog2(NPHYS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              fill_we,
    input  logic [IDX_W-1:0]  fill_addr,
    input  logic [DATA_W-1:0] fill_data,
    input  logic [IDX_W-1:0]  raddr1,
    input  logic [IDX_W-1:0]  raddr2,
    input  logic [IDX_W-1:0]  spill_addr,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] spill_data
);

    logic [DATA_W-1:0] regs [NPHYS];

    // Register storage; fill and datapath writes never coincide, fill wins if they did.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NPHYS; i++) regs[i] <= '0;
        end else if (fill_we) begin
            regs[fill_addr] <= fill_data;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1     = regs[raddr1];
    assign rdata2     = regs[raddr2];
    assign spill_data = regs[spill_addr];

endmodule

// File: rtl/windowed_register_file_spill.sv
// Windowed register file with call/ret window pointer and a memory-backed spill/fill engine.
//
// state  | meaning
// IDLE   | normal operation, call/ret/writes accepted
// SPILL  | writing oldest slot to stack, one word per mem_ack
// FILL   | reading slot back from stack, one word per mem_ack
// COMMIT | update cwp/sp, then return to IDLE
module windowed_register_file_spill
    import windowed_register_file_spill_pkg::*;
#(
    parameter  int DATA_W  = 16,
    parameter  int NUM_WIN = 4,
    parameter  int STRIDE  = 2,
    parameter  int ADDR_W  = 8,
    localparam int SEL_W   = $clog2(2 * STRIDE),
    localparam int CWP_W   = $clog2(NUM_WIN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    input  logic [SEL_W-1:0]  Ri,
    input  logic [SEL_W-1:0]  Rj,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic              win_call,
    input  logic              win_ret,
    output logic              busy,
    output logic [CWP_W-1:0]  cwp,
    output logic [1:0]        win_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int          NPHYS       = NUM_WIN * STRIDE;
    localparam int          IDX_W       = $clog2(NPHYS);
    localparam int          K_W         = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int          RES_W       = CWP_W + 1;
    localparam int unsigned STACK_WORDS = 2 ** ADDR_W;

    wf_state_e         state, state_next;
    logic [RES_W-1:0]  res;
    logic [ADDR_W-1:0] sp;
    logic [K_W-1:0]    k;
    logic              dir_spill;
    logic              idle, do_call, do_ret, stack_full, k_last, start_spill, start_fill;
    logic              fill_we;
    logic [IDX_W-1:0]  rd_idx1, rd_idx2, spill_idx, fill_idx, wr_idx;
    logic [DATA_W-1:0] spill_data;

    assign idle        = (state == ST_IDLE);
    assign busy        = !idle;
    assign do_call     = idle && win_call && !win_ret;
    assign do_ret      = idle && win_ret && !win_call;
    assign stack_full  = (32'(sp) + 32'(STRIDE)) > STACK_WORDS;
    assign k_last      = (k == K_W'(STRIDE - 1));
    assign start_spill = do_call && (res == RES_W'(NUM_WIN - 1)) && !stack_full;
    assign start_fill  = do_ret && (res == RES_W'(1)) && (sp != '0);

    // Spill takes the slot two ahead of cwp (oldest resident); fill restores the slot just behind.
    assign rd_idx1   = IDX_W'(phys_idx(32'(cwp), 32'(Ri), STRIDE, NPHYS));
    assign rd_idx2   = IDX_W'(phys_idx(32'(cwp), 32'(Rj), STRIDE, NPHYS));
    assign wr_idx    = rd_idx1;
    assign spill_idx = IDX_W'(phys_idx(32'(cwp) + 32'd2, 32'(k), STRIDE, NPHYS));
    assign fill_idx  = IDX_W'(phys_idx(32'(cwp) + 32'(NUM_WIN - 1), 32'(k), STRIDE, NPHYS));

    win_reg_array #(
        .DATA_W (DATA_W),
        .NPHYS  (NPHYS)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .we         (reg_write && idle),
        .waddr      (wr_idx),
        .wdata      (write_data),
        .fill_we    (fill_we),
        .fill_addr  (fill_idx),
        .fill_data  (mem_rdata),
        .raddr1     (rd_idx1),
        .raddr2     (rd_idx2),
        .spill_addr (spill_idx),
        .rdata1     (read_data1),
        .rdata2     (read_data2),
        .spill_data (spill_data)
    );

    // Next-state and memory-port outputs; outputs depend only on registered state so they hold while mem_req is high.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_we    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_spill)     state_next = ST_SPILL;
                else if (start_fill) state_next = ST_FILL;
            end
            ST_SPILL: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp + ADDR_W'(k);
                mem_wdata = spill_data;
                if (mem_ack && k_last) state_next = ST_COMMIT;
            end
            ST_FILL: begin
                mem_req  = 1'b1;
                mem_addr = sp - ADDR_W'(STRIDE) + ADDR_W'(k);
                fill_we  = mem_ack;
                if (mem_ack && k_last) state_next = ST_COMMIT;
            end
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register, window bookkeeping and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cwp       <= '0;
            res       <= RES_W'(1);
            sp        <= '0;
            k         <= '0;
            dir_spill <= 1'b0;
            win_err   <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                ST_IDLE: begin
                    k         <= '0;
                    dir_spill <= start_spill;
                    if (do_call) begin
                        if (res < RES_W'(NUM_WIN - 1)) begin
                            cwp <= cwp + 1'b1;
                            res <= res + 1'b1;
                        end else if (stack_full) begin
                            win_err[ERR_STACK_FULL] <= 1'b1;
                        end
                    end
                    if (do_ret) begin
                        if (res > RES_W'(1)) begin
                            cwp <= cwp - 1'b1;
                            res <= res - 1'b1;
                        end else if (sp == '0) begin
                            win_err[ERR_UNDERFLOW] <= 1'b1;
                        end
                    end
                end
                ST_SPILL, ST_FILL: begin
                    if (mem_ack && !k_last) k <= k + 1'b1;
                end
                ST_COMMIT: begin
                    if (dir_spill) begin
                        sp  <= sp + ADDR_W'(STRIDE);
                        cwp <= cwp + 1'b1;
                    end else begin
                        sp  <= sp - ADDR_W'(STRIDE);
                        cwp <= cwp - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_windowed_register_file_spill.sv
// Directed self-checking bench for windowed_register_file_spill (16-bit, 4 windows, stride 2).
module tb_windowed_register_file_spill;

    logic        clk = 1'b0;
    logic        rst, reg_write, win_call, win_ret, mem_ack;
    logic [1:0]  Ri, Rj;
    logic [15:0] write_data, mem_rdata;
    logic [15:0] read_data1, read_data2, mem_wdata;
    logic        busy, mem_req, mem_we;
    logic [1:0]  cwp, win_err;
    logic [7:0]  mem_addr;

    int checks   = 0;
    int failures = 0;
    logic [15:0] mem_model [256];

    windowed_register_file_spill #(
        .DATA_W (16), .NUM_WIN (4), .STRIDE (2), .ADDR_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .reg_write  (reg_write),
        .Ri         (Ri),
        .Rj         (Rj),
        .write_data (write_data),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .win_call   (win_call),
        .win_ret    (win_ret),
        .busy       (busy),
        .cwp        (cwp),
        .win_err    (win_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1; reg_write = 1'b0; win_call = 1'b0; win_ret = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0; Ri = '0; Rj = '0; write_data = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] r, input logic [15:0] d);
        reg_write = 1'b1; Ri = r; write_data = d;
        tick();
        reg_write = 1'b0;
    endtask

    task automatic do_call();
        win_call = 1'b1; tick(); win_call = 1'b0;
    endtask

    task automatic do_ret();
        win_ret = 1'b1; tick(); win_ret = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [1:0] r, input logic [15:0] exp);
        Ri = r; #1;
        check(tag, 32'(read_data1), 32'(exp));
    endtask

    // Acts as the stack memory for one spill or fill of two words, then waits for busy to drop.
    task automatic serve(input bit spill, input int dly, input logic [7:0] base,
                         input logic [15:0] w0, input logic [15:0] w1);
        logic [15:0] expd [2];
        int n;
        expd[0] = w0; expd[1] = w1;
        for (int kk = 0; kk < 2; kk++) begin
            n = 0;
            while (mem_req !== 1'b1 && n < 20) begin tick(); n++; end
            check("mem_req", 32'(mem_req), 32'd1);
            check("mem_we", 32'(mem_we), 32'(spill));
            check("mem_addr", 32'(mem_addr), 32'(base + 8'(kk)));
            if (spill) check("mem_wdata", 32'(mem_wdata), 32'(expd[kk]));
            for (int d = 0; d < dly; d++) begin
                tick();
                check("hold_req", 32'(mem_req), 32'd1);
                check("hold_addr", 32'(mem_addr), 32'(base + 8'(kk)));
                if (spill) check("hold_wdata", 32'(mem_wdata), 32'(expd[kk]));
            end
            mem_ack = 1'b1;
            if (spill) mem_model[mem_addr] = mem_wdata;
            else       mem_rdata = mem_model[mem_addr];
            tick();
            mem_ack = 1'b0; mem_rdata = '0;
        end
        n = 0;
        while (busy !== 1'b0 && n < 10) begin tick(); n++; end
        check("busy_end", 32'(busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = '0;
        apply_reset();

        // Reset state
        #1;
        check("rst_cwp", 32'(cwp), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_win_err", 32'(win_err), 32'd0);
        check("rst_rd1", 32'(read_data1), 32'd0);

        // Ret with empty stack underflows; call+ret together is a no-op
        tick();
        do_ret(); #1;
        check("uflow_err", 32'(win_err), 32'b01);
        check("uflow_cwp", 32'(cwp), 32'd0);
        win_call = 1'b1; win_ret = 1'b1; tick(); win_call = 1'b0; win_ret = 1'b0; #1;
        check("callret_cwp", 32'(cwp), 32'd0);
        check("callret_err", 32'(win_err), 32'b01);

        // Window overlap
        apply_reset();
        check("err_cleared", 32'(win_err), 32'd0);
        do_write(2'd2, 16'd10);
        do_call(); #1;
        check("ovl_cwp", 32'(cwp), 32'd1);
        Rj = 2'd0; #1;
        check("ovl_rd2", 32'(read_data2), 32'd10);
        read_check("ovl_r1", 2'd1, 16'd0);

        // Spill on third call
        apply_reset();
        do_write(2'd0, 16'd7);
        do_write(2'd1, 16'd9);
        do_call(); do_call(); #1;
        check("pre_spill_cwp", 32'(cwp), 32'd2);
        tick();
        do_call(); #1;
        check("spill_busy", 32'(busy), 32'd1);
        check("spill_cwp_hold", 32'(cwp), 32'd2);
        serve(1'b1, 0, 8'd0, 16'd7, 16'd9);
        #1;
        check("spill_cwp", 32'(cwp), 32'd3);

        // Overwrite phys0 from window 3, reads see old value during write cycle
        tick();
        reg_write = 1'b1; Ri = 2'd2; write_data = 16'd1; #1;
        check("rd_old", 32'(read_data1), 32'd7);
        tick(); reg_write = 1'b0; #1;
        check("rd_new", 32'(read_data1), 32'd1);

        // Fill on third ret
        tick();
        do_ret(); do_ret(); #1;
        check("pre_fill_cwp", 32'(cwp), 32'd1);
        tick();
        do_ret(); #1;
        check("fill_busy", 32'(busy), 32'd1);
        serve(1'b0, 0, 8'd0, 16'd0, 16'd0);
        #1;
        check("fill_cwp", 32'(cwp), 32'd0);
        read_check("fill_r0", 2'd0, 16'd7);
        read_check("fill_r1", 2'd1, 16'd9);
        check("fill_err", 32'(win_err), 32'd0);

        // Spill with slow memory acks
        apply_reset();
        do_write(2'd0, 16'd7);
        do_write(2'd1, 16'd9);
        do_call(); do_call(); do_call();
        serve(1'b1, 5, 8'd0, 16'd7, 16'd9);
        #1;
        check("slow_cwp", 32'(cwp), 32'd3);

        // Writes and calls while busy are dropped (window 3: Ri=2 is phys0 holding 7)
        tick();
        do_call();
        reg_write = 1'b1; Ri = 2'd2; write_data = 16'h0055; win_call = 1'b1;
        tick();
        reg_write = 1'b0; win_call = 1'b0;
        serve(1'b1, 0, 8'd2, 16'd0, 16'd0);
        #1;
        check("busy_call_dropped", 32'(cwp), 32'd0);
        read_check("busy_write_dropped", 2'd0, 16'd7);

        // Reset in the middle of a spill
        tick();
        do_call(); #1;
        check("mid_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        tick(); #1;
        check("abort_req", 32'(mem_req), 32'd0);
        check("abort_cwp", 32'(cwp), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            Ri = 2'(r); Rj = 2'(r); #1;
            check("abort_rd1", 32'(read_data1), 32'd0);
            check("abort_rd2", 32'(read_data2), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
